// File: rtl/brick_field.sv
// brick_field: ROWS x COLS brick wall with per-brick hit counters, a registered pixel
// renderer and a one-brick-per-cycle ball/brick collision scan.
module brick_field #(
    parameter int unsigned COLS     = 5,
    parameter int unsigned ROWS     = 2,
    parameter int unsigned BRICK_W  = 124,
    parameter int unsigned BRICK_H  = 20,
    parameter int unsigned GAP      = 4,
    parameter int unsigned ORIGIN_X = 0,
    parameter int unsigned ORIGIN_Y = 0,
    parameter int unsigned MAX_HITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        active_pixels,
    output logic [23:0] vga_color,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    input  logic [5:0]  ball_size,
    input  logic        check_req,
    output logic        busy,
    output logic        check_done,
    output logic        hit,
    output logic        hit_side,
    output logic [5:0]  hit_index,
    output logic [6:0]  bricks_left,
    output logic        level_clear,
    input  logic        level_reload
);
    localparam int unsigned N      = ROWS * COLS;
    localparam int unsigned STEP_X = BRICK_W + GAP;
    localparam int unsigned STEP_Y = BRICK_H + GAP;

    // Two bits per brick for all 64 possible slots; slots >= N stay at zero (dead).
    function automatic logic [127:0] full_wall();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < int'(N); i++) v[2*i +: 2] = 2'(MAX_HITS);
        return v;
    endfunction
    localparam logic [127:0] HITS_INIT = full_wall();

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e       state_q, state_d;
    logic [127:0] hits_q;
    logic [6:0]   bricks_left_q;
    logic [5:0]   idx_q;
    logic [3:0]   col_q;
    logic [2:0]   row_q;
    logic [10:0]  bx_q, by_q;
    logic [5:0]   bs_q;
    logic         hit_q, hit_side_q;
    logic [5:0]   hit_index_q;
    logic [23:0]  color_q, color_d;

    logic         px_in_col, px_in_row;
    logic [3:0]   px_col;
    logic [2:0]   px_row;
    logic [5:0]   px_idx;
    logic [1:0]   px_hits;

    always_comb begin
        px_in_col = 1'b0;
        px_in_row = 1'b0;
        px_col    = '0;
        px_row    = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            if ({1'b0, x} >= 11'(ORIGIN_X + c * STEP_X) &&
                {1'b0, x} <  11'(ORIGIN_X + c * STEP_X + BRICK_W)) begin
                px_in_col = 1'b1;
                px_col    = 4'(c);
            end
        end
        for (int r = 0; r < int'(ROWS); r++) begin
            if ({1'b0, y} >= 11'(ORIGIN_Y + r * STEP_Y) &&
                {1'b0, y} <  11'(ORIGIN_Y + r * STEP_Y + BRICK_H)) begin
                px_in_row = 1'b1;
                px_row    = 3'(r);
            end
        end
        px_idx  = 6'(32'(px_row) * COLS + 32'(px_col));
        px_hits = hits_q[{px_idx, 1'b0} +: 2];
        color_d = '0;
        if (active_pixels && px_in_col && px_in_row) begin
            case (px_hits)
                2'd1:    color_d = 24'hFFFFFF;
                2'd2:    color_d = 24'hFFFF00;
                2'd3:    color_d = 24'hFF8000;
                default: color_d = '0;
            endcase
        end
    end

    // Bounds of the brick under scan, tracked by row/col counters to avoid a divide.
    logic [10:0] s_left, s_right, s_top, s_bot, ball_r, ball_b, ball_cy;
    logic [1:0]  s_hits;
    logic        overlap, side_d, last_idx;

    assign s_left   = 11'(ORIGIN_X) + 11'(col_q) * 11'(STEP_X);
    assign s_right  = s_left + 11'(BRICK_W);
    assign s_top    = 11'(ORIGIN_Y) + 11'(row_q) * 11'(STEP_Y);
    assign s_bot    = s_top + 11'(BRICK_H);
    assign ball_r   = bx_q + 11'(bs_q);
    assign ball_b   = by_q + 11'(bs_q);
    assign ball_cy  = by_q + 11'(bs_q >> 1);
    assign s_hits   = hits_q[{idx_q, 1'b0} +: 2];
    assign overlap  = (s_hits != 2'd0) && (bx_q < s_right) && (ball_r > s_left) &&
                      (by_q < s_bot) && (ball_b > s_top);
    assign side_d   = (ball_cy >= s_top) && (ball_cy < s_bot);
    assign last_idx = (idx_q == 6'(N - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (check_req) state_d = StScan;
            StScan:  if (overlap || last_idx) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            hits_q        <= HITS_INIT;
            bricks_left_q <= 7'(N);
            idx_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            bx_q          <= '0;
            by_q          <= '0;
            bs_q          <= '0;
            hit_q         <= 1'b0;
            hit_side_q    <= 1'b0;
            hit_index_q   <= '0;
            color_q       <= '0;
        end else begin
            color_q <= color_d;
            if (level_reload) begin
                state_q       <= StIdle;
                hits_q        <= HITS_INIT;
                bricks_left_q <= 7'(N);
                hit_q         <= 1'b0;
                hit_side_q    <= 1'b0;
                hit_index_q   <= '0;
            end else begin
                state_q <= state_d;
                if (state_q == StIdle && check_req) begin
                    bx_q        <= {1'b0, ball_x};
                    by_q        <= {1'b0, ball_y};
                    bs_q        <= ball_size;
                    idx_q       <= '0;
                    col_q       <= '0;
                    row_q       <= '0;
                    hit_q       <= 1'b0;
                    hit_side_q  <= 1'b0;
                    hit_index_q <= '0;
                end
                if (state_q == StScan) begin
                    if (overlap) begin
                        hits_q[{idx_q, 1'b0} +: 2] <= s_hits - 2'd1;
                        if (s_hits == 2'd1) bricks_left_q <= bricks_left_q - 7'd1;
                        hit_q       <= 1'b1;
                        hit_side_q  <= side_d;
                        hit_index_q <= idx_q;
                    end else if (!last_idx) begin
                        idx_q <= idx_q + 6'd1;
                        if (col_q == 4'(COLS - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + 3'd1;
                        end else begin
                            col_q <= col_q + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign vga_color   = color_q;
    assign busy        = (state_q == StScan);
    assign check_done  = (state_q == StDone);
    assign hit         = hit_q;
    assign hit_side    = hit_side_q;
    assign hit_index   = hit_index_q;
    assign bricks_left = bricks_left_q;
    assign level_clear = (bricks_left_q == 7'd0);

endmodule

// File: tb/tb_brick_field.sv
// Bench for brick_field: a MAX_HITS=1 and a MAX_HITS=2 instance share stimulus and are
// compared every cycle against a timing-level model, plus directed literal checks.
`timescale 1ns/1ps
module tb_brick_field;
    localparam int COLS = 5, ROWS = 2, N = 10, BW = 124, BH = 20, GAP = 4;

    logic        clk = 1'b0;
    logic        rst, active_pixels, check_req, level_reload;
    logic [9:0]  x, y, ball_x, ball_y;
    logic [5:0]  ball_size;
    logic [23:0] vga_color [2];
    logic        busy [2], check_done [2], hit [2], hit_side [2], level_clear [2];
    logic [5:0]  hit_index [2];
    logic [6:0]  bricks_left [2];

    brick_field #(.MAX_HITS(1)) dut0 (
        .clk(clk), .rst(rst), .x(x), .y(y), .active_pixels(active_pixels),
        .vga_color(vga_color[0]), .ball_x(ball_x), .ball_y(ball_y), .ball_size(ball_size),
        .check_req(check_req), .busy(busy[0]), .check_done(check_done[0]), .hit(hit[0]),
        .hit_side(hit_side[0]), .hit_index(hit_index[0]), .bricks_left(bricks_left[0]),
        .level_clear(level_clear[0]), .level_reload(level_reload)
    );
    brick_field #(.MAX_HITS(2)) dut1 (
        .clk(clk), .rst(rst), .x(x), .y(y), .active_pixels(active_pixels),
        .vga_color(vga_color[1]), .ball_x(ball_x), .ball_y(ball_y), .ball_size(ball_size),
        .check_req(check_req), .busy(busy[1]), .check_done(check_done[1]), .hit(hit[1]),
        .hit_side(hit_side[1]), .hit_index(hit_index[1]), .bricks_left(bricks_left[1]),
        .level_clear(level_clear[1]), .level_reload(level_reload)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0;
    int hits_m [2][N];
    int left_m [2], e_idx [2], chk [2], due [2], tgt [2];
    logic [23:0] e_vga [2];
    bit e_busy [2], e_done [2], e_hit [2], e_side [2], pend [2], tside [2];
    int rec_lat [2], rec_idx [2];
    bit rec_hit [2], rec_side [2];

    function automatic int maxh(int d); return d + 1; endfunction
    function automatic int bl(int c); return c * (BW + GAP); endfunction
    function automatic int bt(int r); return r * (BH + GAP); endfunction

    function automatic logic [23:0] colour_of(int h);
        case (h)
            1:       return 24'hFFFFFF;
            2:       return 24'hFFFF00;
            3:       return 24'hFF8000;
            default: return 24'h0;
        endcase
    endfunction

    function automatic logic [23:0] pix_exp(int d, int px, int py, bit act);
        if (!act) return 24'h0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (px >= bl(c) && px < bl(c) + BW && py >= bt(r) && py < bt(r) + BH)
                    return colour_of(hits_m[d][r * COLS + c]);
        return 24'h0;
    endfunction

    function automatic int find_target(int d, int bx, int by, int bs);
        int l, t;
        for (int i = 0; i < N; i++) begin
            l = bl(i % COLS);
            t = bt(i / COLS);
            if (hits_m[d][i] > 0 && bx < l + BW && bx + bs > l && by < t + BH && by + bs > t)
                return i;
        end
        return -1;
    endfunction

    task automatic reset_model(input int d);
        for (int i = 0; i < N; i++) hits_m[d][i] = maxh(d);
        left_m[d] = N; e_vga[d] = 24'h0; e_busy[d] = 0; e_done[d] = 0;
        e_hit[d] = 0; e_idx[d] = 0; e_side[d] = 0; pend[d] = 0;
    endtask

    // One clock edge of the wall: scan result lands at accept edge + k + 1 (or + N on a miss).
    task automatic model_edge(input int d);
        logic [23:0] nv;
        bit was_done;
        int cy;
        nv = pix_exp(d, int'(x), int'(y), active_pixels);
        was_done = e_done[d];
        e_done[d] = 0;
        chk[d] = 0;
        if (!rst) begin
            reset_model(d);
            chk[d] = 2;
        end else begin
            e_vga[d] = nv;
            if (level_reload) begin
                for (int i = 0; i < N; i++) hits_m[d][i] = maxh(d);
                left_m[d] = N; pend[d] = 0; e_busy[d] = 0; e_hit[d] = 0;
                chk[d] = 1;
            end else if (pend[d] && cyc == due[d]) begin
                pend[d] = 0; e_busy[d] = 0; e_done[d] = 1;
                if (tgt[d] >= 0) begin
                    hits_m[d][tgt[d]]--;
                    if (hits_m[d][tgt[d]] == 0) left_m[d]--;
                    e_hit[d] = 1; e_idx[d] = tgt[d]; e_side[d] = tside[d];
                    chk[d] = 2;
                end else begin
                    e_hit[d] = 0;
                    chk[d] = 1;
                end
            end else if (!pend[d] && !was_done && check_req) begin
                tgt[d] = find_target(d, int'(ball_x), int'(ball_y), int'(ball_size));
                if (tgt[d] >= 0) begin
                    cy = int'(ball_y) + int'(ball_size) / 2;
                    tside[d] = (cy >= bt(tgt[d] / COLS)) && (cy < bt(tgt[d] / COLS) + BH);
                end
                due[d] = cyc + ((tgt[d] >= 0) ? tgt[d] + 1 : N);
                pend[d] = 1; e_busy[d] = 1; e_hit[d] = 0;
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset_model(d);
            chk[d] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) model_edge(d);
        end
    end

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] at cycle %0d: got %0h, want %0h", name, d, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                for (int d = 0; d < 2; d++) begin
                    check("vga_color", d, 32'(vga_color[d]), 32'(e_vga[d]));
                    check("busy", d, 32'(busy[d]), 32'(e_busy[d]));
                    check("check_done", d, 32'(check_done[d]), 32'(e_done[d]));
                    check("bricks_left", d, 32'(bricks_left[d]), 32'(left_m[d]));
                    check("level_clear", d, 32'(level_clear[d]), 32'(left_m[d] == 0));
                    if (chk[d] >= 1) check("hit", d, 32'(hit[d]), 32'(e_hit[d]));
                    if (chk[d] == 2) begin
                        check("hit_index", d, 32'(hit_index[d]), 32'(e_idx[d]));
                        check("hit_side", d, 32'(hit_side[d]), 32'(e_side[d]));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_pix(input int px, input int py, input bit a);
        x = 10'(px); y = 10'(py); active_pixels = a;
    endtask

    task automatic request(input int bx, input int by, input int bs, input int second_at);
        int n;
        ball_x = 10'(bx); ball_y = 10'(by); ball_size = 6'(bs);
        check_req = 1'b1;
        for (int d = 0; d < 2; d++) rec_lat[d] = -1;
        n = 0;
        while ((rec_lat[0] < 0 || rec_lat[1] < 0) && n < 40) begin
            @(negedge clk);
            n++;
            for (int d = 0; d < 2; d++) begin
                if (rec_lat[d] < 0 && check_done[d] === 1'b1) begin
                    rec_lat[d] = n; rec_hit[d] = hit[d];
                    rec_idx[d] = int'(hit_index[d]); rec_side[d] = hit_side[d];
                end
            end
            #1;
            check_req = (n == second_at);
            set_pix((n * 53) % 700, (n * 7) % 60, (n % 3) != 0);
        end
        check_req = 1'b0;
        tick();
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (check_done[0] === 1'b1 || check_done[1] === 1'b1) seen++;
        end
        check(name, 0, 32'(seen), 32'd0);
    endtask

    initial begin
        rst = 1'b0; check_req = 1'b0; level_reload = 1'b0;
        ball_x = '0; ball_y = '0; ball_size = '0;
        set_pix(0, 0, 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("lit_left_reset", 0, 32'(bricks_left[0]), 32'd10);
        check("lit_clear_reset", 0, 32'(level_clear[0]), 32'd0);

        set_pix(0, 0, 1); tick();
        check("lit_pix00", 0, 32'(vga_color[0]), 32'hFFFFFF);
        check("lit_pix00", 1, 32'(vga_color[1]), 32'hFFFF00);
        set_pix(124, 5, 1); tick();
        check("lit_gap", 0, 32'(vga_color[0]), 32'h0);
        set_pix(10, 10, 0); tick();
        check("lit_inactive", 0, 32'(vga_color[0]), 32'h0);

        request(130, 10, 8, -1);
        check("lit_lat_b1", 0, 32'(rec_lat[0]), 32'd3);
        check("lit_hit_b1", 0, 32'(rec_hit[0]), 32'd1);
        check("lit_idx_b1", 0, 32'(rec_idx[0]), 32'd1);
        check("lit_side_b1", 0, 32'(rec_side[0]), 32'd1);
        check("lit_left_b1", 0, 32'(bricks_left[0]), 32'd9);
        check("lit_left_b1", 1, 32'(bricks_left[1]), 32'd10);
        set_pix(130, 10, 1); tick();
        check("lit_pix_b1", 0, 32'(vga_color[0]), 32'h0);
        check("lit_pix_b1", 1, 32'(vga_color[1]), 32'hFFFFFF);

        request(300, 100, 8, 2);
        check("lit_lat_miss", 0, 32'(rec_lat[0]), 32'd11);
        check("lit_hit_miss", 0, 32'(rec_hit[0]), 32'd0);
        check("lit_left_miss", 0, 32'(bricks_left[0]), 32'd9);

        request(10, 18, 6, -1);
        check("lit_lat_b0", 0, 32'(rec_lat[0]), 32'd2);
        check("lit_idx_b0", 0, 32'(rec_idx[0]), 32'd0);
        check("lit_side_b0", 0, 32'(rec_side[0]), 32'd0);

        set_pix(440, 8, 1); tick();
        check("lit_pix_b3", 1, 32'(vga_color[1]), 32'hFFFF00);
        request(440, 8, 4, -1);
        check("lit_lat_b3", 1, 32'(rec_lat[1]), 32'd5);
        check("lit_left_b3a", 1, 32'(bricks_left[1]), 32'd10);
        request(440, 8, 4, -1);
        check("lit_hit_b3b", 1, 32'(rec_hit[1]), 32'd1);
        check("lit_left_b3b", 1, 32'(bricks_left[1]), 32'd9);
        set_pix(440, 8, 1); tick();
        check("lit_pix_b3_dead", 1, 32'(vga_color[1]), 32'h0);

        for (int i = 0; i < N; i++) begin
            request((i % COLS) * 128 + 60, (i / COLS) * 24 + 8, 4, -1);
            request((i % COLS) * 128 + 60, (i / COLS) * 24 + 8, 4, -1);
        end
        check("lit_clear_all", 0, 32'(level_clear[0]), 32'd1);
        check("lit_clear_all", 1, 32'(level_clear[1]), 32'd1);

        level_reload = 1'b1; tick(); level_reload = 1'b0;
        check("lit_left_reload", 1, 32'(bricks_left[1]), 32'd10);
        for (int i = 0; i < N; i++) begin
            set_pix((i % COLS) * 128 + 60, (i / COLS) * 24 + 8, 1); tick();
            check("lit_pix_reload", 1, 32'(vga_color[1]), 32'hFFFF00);
        end

        ball_x = 10'd300; ball_y = 10'd100; ball_size = 6'd8;
        check_req = 1'b1; tick(); check_req = 1'b0;
        repeat (4) tick();
        check("lit_busy_idx4", 0, 32'(busy[0]), 32'd1);
        level_reload = 1'b1; check_req = 1'b1; tick(); level_reload = 1'b0; check_req = 1'b0;
        check("lit_busy_abort", 0, 32'(busy[0]), 32'd0);
        check("lit_hit_abort", 1, 32'(hit[1]), 32'd0);
        watch_no_done("lit_no_done_reload", 14);

        request(130, 10, 8, -1);
        set_pix(0, 0, 1);
        check_req = 1'b1; ball_x = 10'd300; tick(); check_req = 1'b0;
        repeat (2) tick();
        rst = 1'b0; tick(); rst = 1'b1;
        check("lit_rst_vga", 0, 32'(vga_color[0]), 32'h0);
        check("lit_rst_busy", 0, 32'(busy[0]), 32'd0);
        check("lit_rst_hit", 0, 32'(hit[0]), 32'd0);
        check("lit_rst_left", 0, 32'(bricks_left[0]), 32'd10);
        watch_no_done("lit_no_done_rst", 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
